// File: rtl/uc_mult_seq_pkg.sv
// Shared definitions for the shift-and-add multiplier control unit:
// state width, state codes and the recovery target for illegal codes.
package uc_mult_seq_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 4'h0,
    S_LOAD  = 4'h1,
    S_TEST  = 4'h2,
    S_ADD   = 4'h3,
    S_SHIFT = 4'h4,
    S_DONE  = 4'h5
  } state_e;

  // Codes 6..F are never reached normally; if one shows up it falls back here.
  localparam state_e S_ILLEGAL_NEXT = S_IDLE;

endpackage

// File: rtl/uc_mult_seq_if.sv
// Control/handshake bundle between the multiplier control unit and its
// surroundings (top-level control and the shift-and-add datapath).
interface uc_mult_seq_if;
  import uc_mult_seq_pkg::*;

  logic            start;
  logic            abort;
  logic            q0;
  logic            ld;
  logic            clr_acc;
  logic            add_en;
  logic            shift_en;
  logic            busy;
  logic            done;
  logic [ST_W-1:0] State;

  // Master: the environment driving start/abort and supplying q0.
  modport master (
    output start, abort, q0,
    input  ld, clr_acc, add_en, shift_en, busy, done, State
  );

  // Slave: the control unit itself.
  modport slave (
    input  start, abort, q0,
    output ld, clr_acc, add_en, shift_en, busy, done, State
  );
endinterface

// File: rtl/uc_mult_seq_contador.sv
// Iteration counter: cleared on load/abort, counts SHIFT cycles, and flags
// the last iteration (cnt == WIDTH-1) so the FSM can leave the loop.
module uc_contador #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WIDTH - 1);

  // Clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/uc_mult_seq.sv
// Control unit for the multicycle shift-and-add multiplier. Moore FSM:
// IDLE -> LOAD -> (TEST -> [ADD] -> SHIFT) x WIDTH -> DONE -> IDLE.
// All strobes decode from the state register only; abort returns to IDLE.
module uc_mult_seq
  import uc_mult_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uc_mult_seq_if.slave  bus
);

  if (WIDTH < 2 || WIDTH > 15 || (1 << CNT_W) <= WIDTH) begin : g_param_chk
    $error("uc_mult_seq: illegal WIDTH/CNT_W combination");
  end

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             cnt_clr, cnt_en;

  // Counter is cleared on entry to a new operation and on abort.
  assign cnt_clr = bus.abort || (state_q == S_LOAD);
  assign cnt_en  = (state_q == S_SHIFT);

  uc_contador #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .tc    (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = S_TEST;
      S_TEST:  state_d = bus.q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = tc ? S_DONE : S_TEST;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_ILLEGAL_NEXT;
    endcase
    if (bus.abort) state_d = S_IDLE;
  end

  // Moore output decode; illegal codes drive everything low.
  always_comb begin
    bus.ld       = 1'b0;
    bus.clr_acc  = 1'b0;
    bus.add_en   = 1'b0;
    bus.shift_en = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      S_LOAD:  begin bus.ld = 1'b1; bus.clr_acc = 1'b1; bus.busy = 1'b1; end
      S_TEST:  bus.busy = 1'b1;
      S_ADD:   begin bus.add_en = 1'b1; bus.busy = 1'b1; end
      S_SHIFT: begin bus.shift_en = 1'b1; bus.busy = 1'b1; end
      S_DONE:  begin bus.done = 1'b1; bus.busy = 1'b1; end
      default: ;
    endcase
  end

  assign bus.State = state_q;

  // Datapath strobes are mutually exclusive; clearing only happens on load.
  a_onehot_strobes: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({bus.ld, bus.add_en, bus.shift_en}));
  a_clr_with_ld: assert property (@(posedge clk) disable iff (!rst_n)
    (!bus.clr_acc || bus.ld));

endmodule

// File: tb/tb_uc_mult_seq.sv
// Bench for uc_mult_seq: a small shift-and-add datapath is driven by the
// strobes, and results/latency/strobe counts are compared with plain
// arithmetic (a*b, 2+2W+popcount) and with state sequences built from b.
module tb_uc_mult_seq;
  import uc_mult_seq_pkg::*;

  localparam int W = 8;

  typedef int iq_t[$];
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          cyc;
    int          adds;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uc_mult_seq_if bus();

  uc_mult_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: operands loaded on ld, acc has a carry bit.
  logic [7:0] opa = '0, opb = '0;
  logic [7:0] mcand = '0, mpl = '0;
  logic [8:0] acc = '0;
  assign bus.q0 = mpl[0];
  always @(posedge clk) begin
    if (bus.ld) begin
      mcand <= opa;
      mpl   <= opb;
    end
    if (bus.clr_acc)     acc <= '0;
    else if (bus.add_en) acc <= acc + {1'b0, mcand};
    else if (bus.shift_en) {acc, mpl} <= {1'b0, acc, mpl} >> 1;
  end

  int n_tests = 0, n_fail = 0;
  int g_done, g_adds, g_shifts, g_after;
  logic [15:0] g_prod;
  iq_t g_seq;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.ld, bus.clr_acc, bus.add_en, bus.shift_en, bus.busy, bus.done});
  endfunction

  // State codes visited from LOAD to DONE for a given multiplier.
  function automatic iq_t exp_seq(input logic [7:0] b);
    iq_t q;
    q.push_back(1);
    for (int i = 0; i < W; i++) begin
      q.push_back(2);
      if (b[i]) q.push_back(3);
      q.push_back(4);
    end
    q.push_back(5);
    return q;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold);
    opa = a; opb = b;
    g_seq.delete(); g_adds = 0; g_shifts = 0; g_done = -1;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      g_seq.push_back(int'(bus.State));
      if (bus.add_en)   g_adds++;
      if (bus.shift_en) g_shifts++;
      if (bus.done) begin g_done = c; break; end
    end
    @(negedge clk);
    g_after = int'(bus.State);
    g_prod  = {acc[7:0], mpl};
  endtask

  task automatic check_op(input vec_t v);
    iq_t e;
    e = exp_seq(v.b);
    chk("done_cycle", g_done, v.cyc);
    chk("product", int'(g_prod), int'(v.prod));
    chk("add_count", g_adds, v.adds);
    chk("shift_count", g_shifts, W);
    chk("state_after_done", g_after, 0);
    chk("seq_len", g_seq.size(), e.size());
    for (int i = 0; i < e.size() && i < g_seq.size(); i++)
      if (g_seq[i] != e[i]) begin chk("state_seq", g_seq[i], e[i]); break; end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.State == 4'h0) return;
    end
    chk("drain_timeout", int'(bus.State), 0);
  endtask

  task automatic count_done(input int n, output int d);
    d = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) d++;
    end
  endtask

  vec_t tbl[4];
  vec_t v;
  int   d;
  bit   found;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tbl[0] = '{8'h5A, 8'h00, 16'h0000, 18, 0};
    tbl[1] = '{8'hFF, 8'hFF, 16'hFE01, 26, 8};
    tbl[2] = '{8'h03, 8'hA5, 16'h01EF, 22, 4};
    tbl[3] = '{8'h81, 8'h01, 16'h0081, 19, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_state", int'(bus.State), 0);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), 0);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].a, tbl[i].b, 1'b0);
      check_op(tbl[i]);
    end

    // Randomized operands against a*b and 2+2W+popcount
    for (int i = 0; i < 12; i++) begin
      v.a = 8'($urandom_range(0, 255));
      v.b = 8'($urandom_range(0, 255));
      v.prod = 16'(v.a * v.b);
      v.adds = $countones(v.b);
      v.cyc  = 2 + 2 * W + v.adds;
      run_op(v.a, v.b, 1'b0);
      check_op(v);
    end

    // Asynchronous reset in the middle of a SHIFT cycle
    opa = 8'h11; opb = 8'hFF;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.State == 4'h4) found = 1'b1;
    end
    chk("reached_shift", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", int'(bus.State), 0);
    chk("async_reset_outs", outs(), 0);
    @(negedge clk); rst_n = 1'b1;
    count_done(8, d);
    chk("no_done_after_reset", d, 0);
    chk("idle_after_reset", int'(bus.State), 0);

    // Abort in the third TEST, then a fresh operation
    opa = 8'h33; opb = 8'hFF;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    d = 0; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.State == 4'h2) d++;
      if (d == 3) found = 1'b1;
      else @(negedge clk);
    end
    chk("reached_test3", int'(found), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_state", int'(bus.State), 0);
    chk("abort_busy", int'(bus.busy), 0);
    count_done(6, d);
    chk("no_done_after_abort", d, 0);
    v = '{8'h77, 8'h01, 16'h0077, 19, 1};
    run_op(v.a, v.b, 1'b0);
    check_op(v);

    // abort together with start while idle
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_start_idle", int'(bus.State), 0);
    bus.start = 1'b0; bus.abort = 1'b0;

    // abort during DONE: the pulse still shows, then IDLE
    opb = 8'h00;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.State == 4'h5) found = 1'b1;
    end
    chk("done_pulse_abort", int'(bus.done), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("after_done_abort", int'(bus.State), 0);
    chk("after_done_abort_done", int'(bus.done), 0);

    // start held high: start ignored while busy, one IDLE cycle, then LOAD
    v = '{8'h0F, 8'h3C, 16'h0384, 22, 4};
    run_op(v.a, v.b, 1'b1);
    check_op(v);
    @(negedge clk);
    chk("restart_load", int'(bus.State), 1);
    bus.start = 1'b0;
    wait_idle();

    // Illegal state code recovers to IDLE; start is not honoured from it
    @(negedge clk);
    force dut.state_q = 4'hC;
    bus.start = 1'b1;
    #1;
    chk("illegal_state_seen", int'(bus.State), 12);
    chk("illegal_outs", outs(), 0);
    release dut.state_q;
    @(negedge clk);
    chk("illegal_recover", int'(bus.State), 0);
    bus.start = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
